result_writeback_sequencer: RTL and testbench

//  Collects per-port 128-bit checker results when each frame checker reports ready and writes them into
//  the shared 64-bit control memory for host readout. Ports are serviced round-robin.

---
 rtl/result_writeback_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_result_writeback_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : result_writeback_sequencer
// Purpose  : Captures each frame checker's 128-bit result on a rising edge of
//            its ready flag, then writes it to the shared 64-bit control memory
//            as lo word, hi word and a status word. Ports are serviced
//            round-robin through a req/gnt memory handshake.
// Ports    : clk_i           - clock
//            rst_ni          - asynchronous active-low reset
//            check_ready_i   - per-port result valid level (rise = capture)
//            check_results_i - per-port 128-bit results, port p at [p*128 +: 128]
//            clear_i         - pulse, clears done/overrun bits
//            mem_req_o       - memory arbiter request
//            mem_gnt_i       - memory arbiter grant
//            mem_we_o        - memory write enable (only while granted)
//            mem_addr_o      - registered write address
//            mem_din_o       - registered write data
//            busy_o          - burst in progress or any port pending
//            done_o          - per-port result written
// Revision : 1.0 - initial release
// ============================================================================
module result_writeback_sequencer #(
  parameter int unsigned MEM_ADDR_WIDTH = 9,
  parameter int unsigned TEST_PORT      = 4,
  parameter int unsigned RESULT_BASE    = 'h100,
  parameter int unsigned STATUS_ADDR    = 'h0FF
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [TEST_PORT-1:0]        check_ready_i,
  input  logic [TEST_PORT*128-1:0]    check_results_i,
  input  logic                        clear_i,
  output logic                        mem_req_o,
  input  logic                        mem_gnt_i,
  output logic                        mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [63:0]                 mem_din_o,
  output logic                        busy_o,
  output logic [TEST_PORT-1:0]        done_o
);

  localparam int unsigned PTR_W = (TEST_PORT > 1) ? $clog2(TEST_PORT) : 1;
  localparam int unsigned CAND_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WR_LO = 3'd2,
    S_WR_HI = 3'd3,
    S_WR_ST = 3'd4
  } state_e;

  state_e                      state_q, state_d;
  logic [PTR_W-1:0]            sel_q, sel_d;
  logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
  logic [TEST_PORT-1:0]        pending_q, pending_d;
  logic [TEST_PORT-1:0]        overrun_q, overrun_d;
  logic [TEST_PORT-1:0]        done_q, done_d;
  logic [TEST_PORT-1:0]        ready_q;
  logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [63:0]                 din_q, din_d;
  logic [127:0]                shadow_q [TEST_PORT];

  logic [TEST_PORT-1:0]        rise, in_service, capture, overrun_hit, sel_oh;
  logic [PTR_W-1:0]            pick;
  logic                        pick_found;
  logic [CAND_W-1:0]           cand;
  logic [127:0]                shadow_sel;
  logic [MEM_ADDR_WIDTH-1:0]   lo_addr, hi_addr;
  logic [63:0]                 status_word;

  // A rise on a port that is still pending or currently being written keeps
  // the older snapshot and flags an overrun instead.
  always_comb begin
    sel_oh         = '0;
    sel_oh[sel_q]  = 1'b1;
    in_service     = (state_q != S_IDLE) ? sel_oh : '0;
    rise           = check_ready_i & ~ready_q;
    overrun_hit    = rise & (pending_q | in_service);
    capture        = rise & ~(pending_q | in_service);
  end

  // Round-robin search: first pending port at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    cand       = '0;
    for (int i = 0; i < TEST_PORT; i++) begin
      cand = {1'b0, rr_ptr_q} + CAND_W'(i);
      if (cand >= CAND_W'(TEST_PORT)) cand = cand - CAND_W'(TEST_PORT);
      if (!pick_found && pending_q[cand[PTR_W-1:0]]) begin
        pick_found = 1'b1;
        pick       = cand[PTR_W-1:0];
      end
    end
  end

  assign shadow_sel  = shadow_q[sel_q];
  assign lo_addr     = MEM_ADDR_WIDTH'(RESULT_BASE) + MEM_ADDR_WIDTH'({sel_q, 1'b0});
  assign hi_addr     = lo_addr + MEM_ADDR_WIDTH'(1);
  assign status_word = {32'(overrun_q), 32'(done_q | sel_oh)};

  // Next-state and outputs. Address/data registers load only on the edge
  // that enters the corresponding write state, so they hold through stalls.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_ptr_d  = rr_ptr_q;
    pending_d = pending_q | capture;
    overrun_d = (clear_i ? '0 : overrun_q) | overrun_hit;
    done_d    = clear_i ? '0 : done_q;
    addr_d    = addr_q;
    din_d     = din_q;
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d         = S_REQ;
          sel_d           = pick;
          rr_ptr_d        = (pick == PTR_W'(TEST_PORT - 1)) ? '0 : pick + 1'b1;
          pending_d[pick] = 1'b0;
        end
      end
      S_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) begin
          state_d = S_WR_LO;
          addr_d  = lo_addr;
          din_d   = shadow_sel[63:0];
        end
      end
      S_WR_LO: begin
        mem_req_o = 1'b1;
        mem_we_o  = mem_gnt_i;
        if (mem_gnt_i) begin
          state_d = S_WR_HI;
          addr_d  = hi_addr;
          din_d   = shadow_sel[127:64];
        end
      end
      S_WR_HI: begin
        mem_req_o = 1'b1;
        mem_we_o  = mem_gnt_i;
        if (mem_gnt_i) begin
          state_d = S_WR_ST;
          addr_d  = MEM_ADDR_WIDTH'(STATUS_ADDR);
          din_d   = status_word;
        end
      end
      S_WR_ST: begin
        mem_req_o = 1'b1;
        mem_we_o  = mem_gnt_i;
        if (mem_gnt_i) begin
          state_d = S_IDLE;
          done_d  = done_d | sel_oh;   // set wins over a coincident clear
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      rr_ptr_q  <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      done_q    <= '0;
      ready_q   <= '0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
      ready_q   <= check_ready_i;
      addr_q    <= addr_d;
      din_q     <= din_d;
    end
  end

  // Snapshot storage carries no reset; it is only read after a capture.
  generate
    for (genvar p = 0; p < TEST_PORT; p++) begin : g_shadow
      always_ff @(posedge clk_i) begin
        if (capture[p]) shadow_q[p] <= check_results_i[p*128 +: 128];
      end
    end
  endgenerate

  assign mem_addr_o = addr_q;
  assign mem_din_o  = din_q;
  assign busy_o     = (state_q != S_IDLE) || (|pending_q);
  assign done_o     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_result_writeback_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_result_writeback_sequencer
// Purpose  : Self-checking bench for result_writeback_sequencer. A
//            transaction-level reference model (pending set, snapshots,
//            round-robin pointer, count of granted cycles per burst) predicts
//            every cycle's outputs; directed scenarios plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_result_writeback_sequencer;

  localparam int AW   = 9;
  localparam int TP   = 4;
  localparam int BASE = 'h100;
  localparam int STAT = 'h0FF;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [TP-1:0]        ready = '0;
  logic [TP*128-1:0]    results = '0;
  logic                 clear = 1'b0;
  logic                 gnt = 1'b0;
  logic                 req, we, busy;
  logic [AW-1:0]        addr;
  logic [63:0]          din;
  logic [TP-1:0]        done;

  always #5 clk = ~clk;

  result_writeback_sequencer #(
    .MEM_ADDR_WIDTH(AW), .TEST_PORT(TP), .RESULT_BASE(BASE), .STATUS_ADDR(STAT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .check_ready_i(ready), .check_results_i(results),
    .clear_i(clear), .mem_req_o(req), .mem_gnt_i(gnt), .mem_we_o(we),
    .mem_addr_o(addr), .mem_din_o(din), .busy_o(busy), .done_o(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [TP-1:0] m_pend, m_over, m_done, m_prev;
  logic [127:0]  m_shadow [TP];
  bit            m_active;
  int            m_port, m_grants, m_rr;
  logic [63:0]   m_status;
  // observation
  int            n_writes;
  int            lo_order[$];
  logic [63:0]   last_status;

  task automatic model_reset();
    m_pend = '0; m_over = '0; m_done = '0; m_prev = '0;
    m_active = 0; m_port = 0; m_grants = 0; m_rr = 0; m_status = '0;
    for (int p = 0; p < TP; p++) m_shadow[p] = '0;
  endtask

  task automatic check_outputs();
    bit exp_we;
    exp_we = m_active && (m_grants >= 1) && gnt;
    check_value("mem_req", req, m_active);
    check_value("mem_we", we, exp_we);
    check_value("done", done, m_done);
    check_value("busy", busy, m_active || (m_pend != 0));
    if (m_active && m_grants == 1) begin
      check_value("addr_lo", addr, BASE + 2*m_port);
      check_value("din_lo", din, m_shadow[m_port][63:0]);
    end else if (m_active && m_grants == 2) begin
      check_value("addr_hi", addr, BASE + 2*m_port + 1);
      check_value("din_hi", din, m_shadow[m_port][127:64]);
    end else if (m_active && m_grants == 3) begin
      check_value("addr_st", addr, STAT);
      check_value("din_st", din, m_status);
    end
    if (we && gnt) begin
      n_writes++;
      if (addr == AW'(STAT)) last_status = din;
      else if (addr[0] == 1'b0) lo_order.push_back((int'(addr) - BASE) / 2);
    end
  endtask

  // Advance the model across one clock edge using the current inputs.
  task automatic model_step();
    logic [TP-1:0] rise, pend0, over0, done0, svc;
    rise  = ready & ~m_prev;
    pend0 = m_pend; over0 = m_over; done0 = m_done;
    svc   = '0;
    if (m_active) svc[m_port] = 1'b1;
    m_prev = ready;
    m_over = clear ? '0 : over0;
    m_done = clear ? '0 : done0;
    if (!m_active) begin
      for (int i = 0; i < TP; i++) begin
        int idx;
        idx = (m_rr + i) % TP;
        if (!m_active && pend0[idx]) begin
          m_active = 1; m_port = idx; m_grants = 0; m_rr = (idx + 1) % TP;
          m_pend[idx] = 1'b0;
        end
      end
    end else if (gnt) begin
      if (m_grants == 2) m_status = {32'(over0), 32'(done0 | (TP'(1) << m_port))};
      if (m_grants == 3) begin
        m_active = 0;
        m_done[m_port] = 1'b1;
      end else m_grants++;
    end
    for (int p = 0; p < TP; p++) begin
      if (rise[p]) begin
        if (pend0[p] || svc[p]) m_over[p] = 1'b1;
        else begin
          m_pend[p] = 1'b1;
          m_shadow[p] = results[p*128 +: 128];
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ready = '0; clear = 1'b0; gnt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_writes = 0; lo_order.delete(); last_status = '0;
  endtask

  initial begin
    n_writes = 0; last_status = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // reset values
    check_value("rst_req", req, 0);
    check_value("rst_we", we, 0);
    check_value("rst_addr", addr, 0);
    check_value("rst_din", din, 0);
    check_value("rst_busy", busy, 0);
    check_value("rst_done", done, 0);
    rst_n = 1'b1;

    // 1: single port, grant tied high
    do_reset();
    gnt = 1'b1;
    results[2*128 +: 128] = 128'hAAAA_AAAA_AAAA_AAAA_BBBB_BBBB_BBBB_BBBB;
    ready[2] = 1'b1;
    run(5);
    check_value("t1_done_c4", done, 4'b0000);
    run(1);
    check_value("t1_done_c5", done, 4'b0100);
    check_value("t1_writes", n_writes, 3);
    check_value("t1_status", last_status, 64'h4);
    ready[2] = 1'b0;
    run(2);

    // 2: three simultaneous rises, round-robin order 0,1,3
    do_reset();
    gnt = 1'b1;
    for (int p = 0; p < TP; p++) results[p*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    ready = 4'b1011;
    run(20);
    check_value("t2_n_bursts", lo_order.size(), 3);
    if (lo_order.size() == 3) begin
      check_value("t2_order0", lo_order[0], 0);
      check_value("t2_order1", lo_order[1], 1);
      check_value("t2_order2", lo_order[2], 3);
    end
    check_value("t2_status", last_status, 64'hB);
    check_value("t2_done", done, 4'b1011);
    // pointer wrapped to 0: ports 3 and 0 together must go 0 first
    ready = '0; run(1);
    ready = 4'b1001; lo_order.delete(); run(12);
    if (lo_order.size() >= 1) check_value("t2_rr_wrap", lo_order[0], 0);
    else check_value("t2_rr_wrap_seen", lo_order.size(), 1);

    // 3: grant toggling mid-burst
    do_reset();
    results[1*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    ready[1] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      gnt = i[0];
      cycle();
    end
    check_value("t3_writes", n_writes, 3);
    check_value("t3_done", done, 4'b0010);

    // 4: re-rise while pending -> overrun, then clear
    do_reset();
    gnt = 1'b0;
    results[1*128 +: 128] = {4{32'h1111_2222}};
    ready[1] = 1'b1; run(1);
    ready[1] = 1'b0; run(1);
    results[1*128 +: 128] = {4{32'h3333_4444}};
    ready[1] = 1'b1; run(1);
    gnt = 1'b1; run(8);
    check_value("t4_status", last_status, 64'h0000_0002_0000_0002);
    clear = 1'b1; run(1); clear = 1'b0;
    check_value("t4_clear_done", done, 0);
    run(1);
    check_value("t4_status_clr", last_status, 64'h0000_0002_0000_0002);

    // 5: asynchronous reset during the hi-word write
    do_reset();
    gnt = 1'b1;
    results[3*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    ready[3] = 1'b1;
    begin
      int k;
      k = 0;
      while (!(m_active && m_grants == 2) && k < 20) begin cycle(); k++; end
      check_value("t5_reach_hi", (m_active && m_grants == 2), 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check_value("t5_req_drop", req, 0);
    check_value("t5_we_drop", we, 0);
    check_value("t5_done", done, 0);
    check_value("t5_busy", busy, 0);
    do_reset();
    gnt = 1'b1;
    results[0 +: 128] = {$urandom, $urandom, $urandom, $urandom};
    ready[0] = 1'b1;
    run(8);
    check_value("t5_after_done", done, 4'b0001);
    check_value("t5_after_writes", n_writes, 3);

    // 6: level held high for 100 cycles -> one capture
    do_reset();
    gnt = 1'b1;
    ready[2] = 1'b1;
    run(100);
    check_value("t6_writes", n_writes, 3);
    check_value("t6_done", done, 4'b0100);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      for (int p = 0; p < TP; p++) begin
        if ($urandom_range(0, 3) == 0) ready[p] = ~ready[p];
        if ($urandom_range(0, 1) == 0) results[p*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
      end
      gnt   = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 19) == 0);
      cycle();
    end
    clear = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
